mem_arbiter: RTL and testbench

- Arbitrates the single-port synchronous main memory between the CPU core and the JTAG debug port.
- Sequences every access through a fixed issue/response cycle.
- Buffers the JTAG port's one-cycle memory pulse so it is never lost.
- Drives the memory control bus that the core and JTAG previously drove directly.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its three clients: CPU core, JTAG debug port and main memory.
// The arbiter takes the slave view; the surrounding system (or a bench) takes the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_coreReq;
    logic [ADDR_W-1:0] i_coreAddr;
    logic [DATA_W-1:0] i_coreWdata;
    logic              i_coreWr;
    logic              o_coreAck;
    logic [DATA_W-1:0] o_coreRdata;

    logic              i_jtagEn;
    logic [ADDR_W-1:0] i_jtagAddr;
    logic [DATA_W-1:0] i_jtagWdata;
    logic              i_jtagWr;
    logic              o_jtagDone;
    logic [DATA_W-1:0] o_jtagRdata;
    logic              o_jtagOvf;
    logic              i_jtagOvfClr;

    logic [ADDR_W-1:0] o_memAddr;
    logic [DATA_W-1:0] o_memWdata;
    logic              o_memWr;
    logic              o_memEn;
    logic [DATA_W-1:0] i_memRdata;

    modport slave (
        input  i_coreReq, i_coreAddr, i_coreWdata, i_coreWr,
        output o_coreAck, o_coreRdata,
        input  i_jtagEn, i_jtagAddr, i_jtagWdata, i_jtagWr, i_jtagOvfClr,
        output o_jtagDone, o_jtagRdata, o_jtagOvf,
        output o_memAddr, o_memWdata, o_memWr, o_memEn,
        input  i_memRdata
    );

    modport master (
        output i_coreReq, i_coreAddr, i_coreWdata, i_coreWr,
        input  o_coreAck, o_coreRdata,
        output i_jtagEn, i_jtagAddr, i_jtagWdata, i_jtagWr, i_jtagOvfClr,
        input  o_jtagDone, o_jtagRdata, o_jtagOvf,
        input  o_memAddr, o_memWdata, o_memWr, o_memEn,
        output i_memRdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port synchronous memory between the CPU core and the JTAG debug port.
// Every access runs IDLE/RSP -> ACC -> RSP; the JTAG one-cycle pulse is held in a one-deep buffer.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pAddr_q, pAddr_d;
    logic [DATA_W-1:0] pWdata_q, pWdata_d;
    logic              pWr_q, pWr_d;
    logic              lastJtag_q, lastJtag_d;
    logic              srcJtag_q, srcJtag_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              memWr_q, memWr_d;
    logic [DATA_W-1:0] jtagRdata_q, jtagRdata_d;
    logic              ovf_q, ovf_d;

    logic coreElig, jtagElig, grantCore, grantJtag, ovfSet;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pAddr_d     = pAddr_q;
        pWdata_d    = pWdata_q;
        pWr_d       = pWr_q;
        lastJtag_d  = lastJtag_q;
        srcJtag_d   = srcJtag_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        memWr_d     = memWr_q;
        jtagRdata_d = jtagRdata_q;
        ovf_d       = ovf_q;

        // A request seen by the core during RSP is the one being acked, so it only counts in IDLE.
        coreElig  = (state_q == IDLE) && bus.i_coreReq;
        jtagElig  = (state_q != ACC) && pend_q;
        grantJtag = jtagElig && (!coreElig || !lastJtag_q);
        grantCore = coreElig && !grantJtag;
        ovfSet    = bus.i_jtagEn && pend_q && !grantJtag;

        case (state_q)
            IDLE:    if (grantCore || grantJtag) state_d = ACC;
            ACC:     state_d = RSP;
            RSP:     state_d = grantJtag ? ACC : IDLE;
            default: state_d = IDLE;
        endcase

        if (grantCore) begin
            memAddr_d  = bus.i_coreAddr;
            memWdata_d = bus.i_coreWdata;
            memWr_d    = bus.i_coreWr;
            srcJtag_d  = 1'b0;
            lastJtag_d = 1'b0;
        end else if (grantJtag) begin
            memAddr_d  = pAddr_q;
            memWdata_d = pWdata_q;
            memWr_d    = pWr_q;
            srcJtag_d  = 1'b1;
            lastJtag_d = 1'b1;
        end

        if (state_q == RSP && srcJtag_q && !memWr_q) jtagRdata_d = bus.i_memRdata;

        // The buffer slot frees up on the grant edge, so a pulse on that edge is captured, not dropped.
        if (bus.i_jtagEn && (!pend_q || grantJtag)) begin
            pend_d   = 1'b1;
            pAddr_d  = bus.i_jtagAddr;
            pWdata_d = bus.i_jtagWdata;
            pWr_d    = bus.i_jtagWr;
        end else if (grantJtag) begin
            pend_d = 1'b0;
        end

        if (ovfSet)                ovf_d = 1'b1;
        else if (bus.i_jtagOvfClr) ovf_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            lastJtag_q  <= 1'b1;
            srcJtag_q   <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memWr_q     <= 1'b0;
            jtagRdata_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            lastJtag_q  <= lastJtag_d;
            srcJtag_q   <= srcJtag_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            memWr_q     <= memWr_d;
            jtagRdata_q <= jtagRdata_d;
            ovf_q       <= ovf_d;
        end
    end

    // Buffered JTAG payload is only meaningful while pend_q is set.
    always_ff @(posedge i_clk) begin
        pAddr_q  <= pAddr_d;
        pWdata_q <= pWdata_d;
        pWr_q    <= pWr_d;
    end

    assign bus.o_memEn     = (state_q == ACC);
    assign bus.o_memAddr   = memAddr_q;
    assign bus.o_memWdata  = memWdata_q;
    assign bus.o_memWr     = memWr_q;
    assign bus.o_coreAck   = (state_q == RSP) && !srcJtag_q;
    assign bus.o_coreRdata = (bus.o_coreAck && !memWr_q) ? bus.i_memRdata : '0;
    assign bus.o_jtagDone  = (state_q == RSP) && srcJtag_q;
    assign bus.o_jtagRdata = jtagRdata_q;
    assign bus.o_jtagOvf   = ovf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a timestamp-based reference model of the arbitration rules.
module tb_mem_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : ((a * 16'h9E37) ^ 16'h5A5A);
    endfunction

    logic [15:0] rd_q = 16'h0;
    always @(posedge clk) if (bus.o_memEn) rd_q <= mem_f(bus.o_memAddr);
    assign bus.i_memRdata = rd_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stimulus for the next cycle
    logic        v_rstn, v_coreReq, v_coreWr, v_jtagEn, v_jtagWr, v_clr;
    logic [15:0] v_coreAddr, v_coreWdata, v_jtagAddr, v_jtagWdata;

    // Reference model: an access granted in cycle g issues in g+1 and responds in g+2
    int          cyc = 0;
    int          m_g = -10;
    bit          m_known = 0;
    bit          m_accJ, m_accWr, m_jp, m_jpWr, m_lastJ, m_ovf;
    logic [15:0] m_accAddr, m_accWdata, m_jpAddr, m_jpWdata, m_jrd;

    task automatic tick();
        bit iss, rsp, idle, ce, je, gj, gc, oset;
        @(negedge clk);
        iss  = (cyc == m_g + 1);
        rsp  = (cyc == m_g + 2);
        idle = !iss && !rsp;
        if (m_known) begin
            chk("memEn",     32'(bus.o_memEn),     32'(iss));
            chk("memAddr",   32'(bus.o_memAddr),   32'(m_accAddr));
            chk("memWdata",  32'(bus.o_memWdata),  32'(m_accWdata));
            chk("memWr",     32'(bus.o_memWr),     32'(m_accWr));
            chk("coreAck",   32'(bus.o_coreAck),   32'(rsp && !m_accJ));
            chk("coreRdata", 32'(bus.o_coreRdata),
                32'((rsp && !m_accJ && !m_accWr) ? mem_f(m_accAddr) : 16'h0));
            chk("jtagDone",  32'(bus.o_jtagDone),  32'(rsp && m_accJ));
            chk("jtagRdata", 32'(bus.o_jtagRdata), 32'(m_jrd));
            chk("jtagOvf",   32'(bus.o_jtagOvf),   32'(m_ovf));
        end
        if (rsp && !m_accJ) v_coreReq = 1'b0;
        rstn             = v_rstn;
        bus.i_coreReq    = v_coreReq;
        bus.i_coreAddr   = v_coreAddr;
        bus.i_coreWdata  = v_coreWdata;
        bus.i_coreWr     = v_coreWr;
        bus.i_jtagEn     = v_jtagEn;
        bus.i_jtagAddr   = v_jtagAddr;
        bus.i_jtagWdata  = v_jtagWdata;
        bus.i_jtagWr     = v_jtagWr;
        bus.i_jtagOvfClr = v_clr;
        if (!v_rstn) begin
            m_known = 1; m_g = -10; m_accJ = 0; m_accWr = 0; m_accAddr = 0; m_accWdata = 0;
            m_jp = 0; m_lastJ = 1; m_ovf = 0; m_jrd = 0;
            v_coreReq = 1'b0;
        end else begin
            if (rsp && m_accJ && !m_accWr) m_jrd = mem_f(m_accAddr);
            ce   = idle && v_coreReq;
            je   = (idle || rsp) && m_jp;
            gj   = je && (!ce || !m_lastJ);
            gc   = ce && !gj;
            oset = v_jtagEn && m_jp && !gj;
            if (gc) begin
                m_accJ = 0; m_accAddr = v_coreAddr; m_accWdata = v_coreWdata; m_accWr = v_coreWr;
                m_lastJ = 0; m_g = cyc;
            end else if (gj) begin
                m_accJ = 1; m_accAddr = m_jpAddr; m_accWdata = m_jpWdata; m_accWr = m_jpWr;
                m_lastJ = 1; m_g = cyc; m_jp = 0;
            end
            if (v_jtagEn && !oset) begin
                m_jp = 1; m_jpAddr = v_jtagAddr; m_jpWdata = v_jtagWdata; m_jpWr = v_jtagWr;
            end
            if (oset)       m_ovf = 1;
            else if (v_clr) m_ovf = 0;
        end
        v_jtagEn = 1'b0;
        v_clr    = 1'b0;
        cyc++;
    endtask

    task automatic core_req(input logic [15:0] a, input logic [15:0] d, input logic w);
        v_coreReq = 1'b1; v_coreAddr = a; v_coreWdata = d; v_coreWr = w;
    endtask

    task automatic jtag_pulse(input logic [15:0] a, input logic [15:0] d, input logic w);
        v_jtagEn = 1'b1; v_jtagAddr = a; v_jtagWdata = d; v_jtagWr = w;
    endtask

    initial begin
        v_rstn = 0; v_coreReq = 0; v_coreWr = 0; v_jtagEn = 0; v_jtagWr = 0; v_clr = 0;
        v_coreAddr = 0; v_coreWdata = 0; v_jtagAddr = 0; v_jtagWdata = 0;
        rstn = 0;
        bus.i_coreReq = 0; bus.i_coreAddr = 0; bus.i_coreWdata = 0; bus.i_coreWr = 0;
        bus.i_jtagEn = 0; bus.i_jtagAddr = 0; bus.i_jtagWdata = 0; bus.i_jtagWr = 0;
        bus.i_jtagOvfClr = 0;

        tick(); tick();
        v_rstn = 1;
        chk("rst_memEn",   32'(bus.o_memEn),     32'h0);
        chk("rst_memAddr", 32'(bus.o_memAddr),   32'h0);
        chk("rst_coreAck", 32'(bus.o_coreAck),   32'h0);
        chk("rst_jtagRd",  32'(bus.o_jtagRdata), 32'h0);
        chk("rst_ovf",     32'(bus.o_jtagOvf),   32'h0);

        // Core read of 0x0040
        core_req(16'h0040, 16'h1111, 1'b0);
        tick();
        tick();
        chk("t1_memEn",   32'(bus.o_memEn),   32'h1);
        chk("t1_memAddr", 32'(bus.o_memAddr), 32'h0040);
        chk("t1_memWr",   32'(bus.o_memWr),   32'h0);
        tick();
        chk("t1_ack",     32'(bus.o_coreAck),   32'h1);
        chk("t1_rdata",   32'(bus.o_coreRdata), 32'hBEEF);
        chk("t1_memEnLo", 32'(bus.o_memEn),     32'h0);
        tick();
        chk("t1_ackOnce", 32'(bus.o_coreAck),   32'h0);

        // JTAG write 0x1234 <= 0xA5A5
        jtag_pulse(16'h1234, 16'hA5A5, 1'b1);
        tick(); tick(); tick();
        chk("t2_memEn",    32'(bus.o_memEn),    32'h1);
        chk("t2_memWr",    32'(bus.o_memWr),    32'h1);
        chk("t2_memWdata", 32'(bus.o_memWdata), 32'hA5A5);
        chk("t2_memAddr",  32'(bus.o_memAddr),  32'h1234);
        tick();
        chk("t2_done",     32'(bus.o_jtagDone), 32'h1);
        tick();
        chk("t2_jtagRd",   32'(bus.o_jtagRdata), 32'h0);

        // Tie with lastGrant=JTAG: core first, then JTAG; next tie goes to core again
        jtag_pulse(16'h0300, 16'h0, 1'b0);
        tick();
        core_req(16'h0500, 16'h0, 1'b0);
        tick(); tick();
        chk("t3_coreFirst", 32'(bus.o_memAddr), 32'h0500);
        tick(); tick();
        chk("t3_jtagNext",  32'(bus.o_memAddr), 32'h0300);
        chk("t3_jtagEn",    32'(bus.o_memEn),   32'h1);
        tick(); tick();
        chk("t3_jtagRd",    32'(bus.o_jtagRdata), 32'(mem_f(16'h0300)));
        jtag_pulse(16'h0700, 16'h0, 1'b0);
        tick();
        core_req(16'h0900, 16'h0, 1'b0);
        tick(); tick();
        chk("t3_tie2Core",  32'(bus.o_memAddr), 32'h0900);
        repeat (5) tick();

        // Overflow: second pulse while first waits behind a core access
        core_req(16'h0A00, 16'h0, 1'b0);
        jtag_pulse(16'h0B00, 16'h0, 1'b0);
        tick();
        jtag_pulse(16'h0C00, 16'h0, 1'b0);
        tick(); tick();
        chk("t4_ovfSet",   32'(bus.o_jtagOvf),  32'h1);
        tick();
        chk("t4_firstRun", 32'(bus.o_memAddr),  32'h0B00);
        tick(); tick(); tick();
        chk("t4_noSecond", 32'(bus.o_memEn),    32'h0);
        chk("t4_addrHeld", 32'(bus.o_memAddr),  32'h0B00);
        v_clr = 1'b1;
        tick(); tick();
        chk("t4_ovfClr",   32'(bus.o_jtagOvf),  32'h0);

        // Pulse on the grant edge of the pending request
        jtag_pulse(16'h0D00, 16'h0, 1'b0);
        tick();
        jtag_pulse(16'h0E00, 16'h7777, 1'b1);
        tick(); tick();
        chk("t5_firstEn",   32'(bus.o_memEn),   32'h1);
        chk("t5_firstAddr", 32'(bus.o_memAddr), 32'h0D00);
        tick();
        chk("t5_gap",       32'(bus.o_memEn),   32'h0);
        tick();
        chk("t5_secondEn",  32'(bus.o_memEn),   32'h1);
        chk("t5_secondAdr", 32'(bus.o_memAddr), 32'h0E00);
        chk("t5_noOvf",     32'(bus.o_jtagOvf), 32'h0);
        repeat (3) tick();

        // Reset during ACC of a core read, with a JTAG request pending
        core_req(16'h0F00, 16'h0, 1'b0);
        jtag_pulse(16'h0123, 16'h0, 1'b0);
        tick();
        v_rstn = 1'b0;
        tick();
        v_rstn = 1'b1;
        tick();
        chk("t6_memEn",    32'(bus.o_memEn),     32'h0);
        chk("t6_memAddr",  32'(bus.o_memAddr),   32'h0);
        chk("t6_coreAck",  32'(bus.o_coreAck),   32'h0);
        chk("t6_jtagDone", 32'(bus.o_jtagDone),  32'h0);
        chk("t6_jtagRd",   32'(bus.o_jtagRdata), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_noPend", 32'(bus.o_memEn), 32'h0);
        end
        core_req(16'h0F00, 16'h0, 1'b0);
        tick(); tick();
        chk("t6_reEn",    32'(bus.o_memAddr),   32'h0F00);
        tick();
        chk("t6_reAck",   32'(bus.o_coreAck),   32'h1);
        chk("t6_reRdata", 32'(bus.o_coreRdata), 32'(mem_f(16'h0F00)));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!v_coreReq && $urandom_range(0, 2) == 0)
                core_req(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0)
                jtag_pulse(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 15) == 0) v_clr = 1'b1;
            v_rstn = ($urandom_range(0, 299) != 0);
            tick();
        end
        v_rstn = 1'b1;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
